// File: rtl/multicycle_control_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm_if
//
// Purpose:
//   Bundles the control/status signals that connect the multicycle sequencing
//   controller to the multicycle datapath.
//
// Signals (direction as seen from the controller, modport master):
//   Op[5:0]       in   instruction opcode from IR
//   Funct[5:0]    in   instruction funct field from IR
//   RtLsb         in   IR bit 16 (bgez = 1, bltz = 0 for Op 000001)
//   Zero          in   ALU result == 0
//   Neg           in   ALU result bit 31
//   MemReady      in   memory handshake (only with MULTICYCLE_MEM_WAIT_EN)
//   IorD          out  memory address select (0 PC, 1 ALUOut)
//   MemWrite      out  data memory write strobe
//   IRWrite       out  IR load enable
//   RegDst        out  register destination (1 rd, 0 rt)
//   MemtoReg      out  writeback source (1 MDR, 0 ALUOut)
//   RegWrite      out  register file write enable
//   ALUSrcA       out  ALU A select (0 PC, 1 A reg)
//   ALUSrcB[1:0]  out  ALU B select (0 B, 1 const 4, 2 SignImm, 3 SignImm<<2)
//   BZero         out  force ALU B operand to zero
//   ALUOp[2:0]    out  ALU operation code
//   PCSrc[1:0]    out  PC source (0 ALU, 1 ALUOut, 2 jump target, 3 A reg)
//   PCEn          out  PC load enable
//   IllegalOp     out  one-cycle pulse on an unsupported opcode
//   State[3:0]    out  current controller state (debug)
//
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN adds the MemReady signal.
// -----------------------------------------------------------------------------
interface multicycle_control_fsm_if;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       RtLsb;
   logic       Zero;
   logic       Neg;
`ifdef MULTICYCLE_MEM_WAIT_EN
   logic       MemReady;
`endif
   logic       IorD;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       BZero;
   logic [2:0] ALUOp;
   logic [1:0] PCSrc;
   logic       PCEn;
   logic       IllegalOp;
   logic [3:0] State;

   // Controller side
   modport master (
`ifdef MULTICYCLE_MEM_WAIT_EN
      input  MemReady,
`endif
      input  Op, Funct, RtLsb, Zero, Neg,
      output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
      output ALUSrcA, ALUSrcB, BZero, ALUOp, PCSrc, PCEn, IllegalOp, State
   );

   // Datapath side
   modport slave (
`ifdef MULTICYCLE_MEM_WAIT_EN
      output MemReady,
`endif
      output Op, Funct, RtLsb, Zero, Neg,
      input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
      input  ALUSrcA, ALUSrcB, BZero, ALUOp, PCSrc, PCEn, IllegalOp, State
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Purpose:
//   Moore-style sequencing controller for the multicycle MIPS datapath. Steps
//   one instruction at a time through fetch, decode, execute, memory and
//   writeback, sharing a single ALU, memory and register file. Supported
//   subset: R-type (incl. jr), addi/addiu/andi/ori/xori/slti/sltiu, lw/sw,
//   beq/bne/blez/bgtz/bltz/bgez, j.
//
// Ports:
//   clk   in  system clock, all state on the rising edge
//   rst   in  synchronous active-high reset
//   bus   multicycle_control_fsm_if.master  (decode inputs, control outputs)
//
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN
//   When defined, bus.MemReady stretches FETCH, MEMRD and MEMWR until the
//   memory acknowledges. When undefined, memory is treated as single-cycle.
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
   parameter logic [2:0] ALUOP_ADD   = 3'd0,
   parameter logic [2:0] ALUOP_SUB   = 3'd1,
   parameter logic [2:0] ALUOP_FUNCT = 3'd2
) (
   input  logic                            clk,
   input  logic                            rst,
   multicycle_control_fsm_if.master        bus
);

   // Remaining ALU codes shared with the pipeline decoder
   localparam logic [2:0] ALUOP_AND = 3'd3;
   localparam logic [2:0] ALUOP_OR  = 3'd4;
   localparam logic [2:0] ALUOP_XOR = 3'd5;
   localparam logic [2:0] ALUOP_SLT = 3'd7;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_SLTIU  = 6'b001011;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] FUNCT_JR  = 6'b001000;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTEXEC  = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      IMMEXEC = 4'd9,
      IMMWB   = 4'd10,
      JUMP    = 4'd11,
      JR      = 4'd12
   } state_t;

   state_t stateReg;
   state_t stateNext;

   logic memReady;

   // Registered control decisions are not needed: every output is decoded
   // from the current state (plus Op for ALUOp/BZero, Zero/Neg for PCEn).
   logic       iorD;
   logic       memWrite;
   logic       irWrite;
   logic       regDst;
   logic       memtoReg;
   logic       regWrite;
   logic       aluSrcA;
   logic [1:0] aluSrcB;
   logic       bZero;
   logic [2:0] aluOp;
   logic [1:0] pcSrc;
   logic       pcEn;
   logic       illegalOp;

   // Opcode classification
   logic       isLoadStore;
   logic       isImm;
   logic       isBranch;
   logic       isSingleOpBranch;
   logic [2:0] immAluOp;
   logic       branchTaken;

`ifdef MULTICYCLE_MEM_WAIT_EN
   assign memReady = bus.MemReady;
`else
   assign memReady = 1'b1;
`endif

   assign isLoadStore      = (bus.Op == OP_LW) || (bus.Op == OP_SW);
   assign isBranch         = (bus.Op == OP_BEQ)  || (bus.Op == OP_BNE) ||
                             (bus.Op == OP_BLEZ) || (bus.Op == OP_BGTZ) ||
                             (bus.Op == OP_REGIMM);
   // blez/bgtz/bltz/bgez compare rs against zero, so B is forced to 0
   assign isSingleOpBranch = (bus.Op == OP_REGIMM) || (bus.Op == OP_BLEZ) ||
                             (bus.Op == OP_BGTZ);

   always_comb begin
      isImm    = 1'b1;
      immAluOp = ALUOP_ADD;
      case (bus.Op)
         OP_ADDI, OP_ADDIU: immAluOp = ALUOP_ADD;
         OP_ANDI:           immAluOp = ALUOP_AND;
         OP_ORI:            immAluOp = ALUOP_OR;
         OP_XORI:           immAluOp = ALUOP_XOR;
         OP_SLTI, OP_SLTIU: immAluOp = ALUOP_SLT;
         default:           isImm    = 1'b0;
      endcase
   end

   // Branch condition from the A-B (or A-0) result flags
   always_comb begin
      branchTaken = 1'b0;
      case (bus.Op)
         OP_BEQ:    branchTaken = bus.Zero;
         OP_BNE:    branchTaken = !bus.Zero;
         OP_BLEZ:   branchTaken = bus.Neg | bus.Zero;
         OP_BGTZ:   branchTaken = !bus.Neg & !bus.Zero;
         OP_REGIMM: branchTaken = bus.RtLsb ? !bus.Neg : bus.Neg;
         default:   branchTaken = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg <= FETCH;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next-state and output decode
   always_comb begin
      stateNext = stateReg;
      iorD      = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      regDst    = 1'b0;
      memtoReg  = 1'b0;
      regWrite  = 1'b0;
      aluSrcA   = 1'b0;
      aluSrcB   = 2'd0;
      bZero     = 1'b0;
      aluOp     = ALUOP_ADD;
      pcSrc     = 2'd0;
      pcEn      = 1'b0;
      illegalOp = 1'b0;

      case (stateReg)
         FETCH: begin
            // PC <= PC + 4 and IR load happen together once memory is ready
            iorD      = 1'b0;
            aluSrcA   = 1'b0;
            aluSrcB   = 2'd1;
            aluOp     = ALUOP_ADD;
            pcSrc     = 2'd0;
            irWrite   = memReady;
            pcEn      = memReady;
            stateNext = memReady ? DECODE : FETCH;
         end
         DECODE: begin
            // ALUOut <= PC + (SignImm << 2): branch target ready for BRANCH
            aluSrcA = 1'b0;
            aluSrcB = 2'd3;
            aluOp   = ALUOP_ADD;
            if (isLoadStore) begin
               stateNext = MEMADR;
            end else if (bus.Op == OP_RTYPE) begin
               stateNext = (bus.Funct == FUNCT_JR) ? JR : RTEXEC;
            end else if (isImm) begin
               stateNext = IMMEXEC;
            end else if (isBranch) begin
               stateNext = BRANCH;
            end else if (bus.Op == OP_J) begin
               stateNext = JUMP;
            end else begin
               illegalOp = 1'b1;
               stateNext = FETCH;
            end
         end
         MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'd2;
            aluOp   = ALUOP_ADD;
            if (bus.Op == OP_LW) begin
               stateNext = MEMRD;
            end else if (bus.Op == OP_SW) begin
               stateNext = MEMWR;
            end else begin
               stateNext = FETCH;
            end
         end
         MEMRD: begin
            iorD      = 1'b1;
            stateNext = memReady ? MEMWB : MEMRD;
         end
         MEMWB: begin
            regDst    = 1'b0;
            memtoReg  = 1'b1;
            regWrite  = 1'b1;
            stateNext = FETCH;
         end
         MEMWR: begin
            // Strobe held for every cycle of a stretched write
            iorD      = 1'b1;
            memWrite  = 1'b1;
            stateNext = memReady ? FETCH : MEMWR;
         end
         RTEXEC: begin
            aluSrcA   = 1'b1;
            aluSrcB   = 2'd0;
            aluOp     = ALUOP_FUNCT;
            stateNext = ALUWB;
         end
         ALUWB: begin
            regDst    = 1'b1;
            memtoReg  = 1'b0;
            regWrite  = 1'b1;
            stateNext = FETCH;
         end
         BRANCH: begin
            aluSrcA   = 1'b1;
            aluSrcB   = 2'd0;
            aluOp     = ALUOP_SUB;
            bZero     = isSingleOpBranch;
            pcSrc     = 2'd1;
            pcEn      = branchTaken;
            stateNext = FETCH;
         end
         IMMEXEC: begin
            aluSrcA   = 1'b1;
            aluSrcB   = 2'd2;
            aluOp     = immAluOp;
            stateNext = IMMWB;
         end
         IMMWB: begin
            regDst    = 1'b0;
            regWrite  = 1'b1;
            stateNext = FETCH;
         end
         JUMP: begin
            pcSrc     = 2'd2;
            pcEn      = 1'b1;
            stateNext = FETCH;
         end
         JR: begin
            pcSrc     = 2'd3;
            pcEn      = 1'b1;
            stateNext = FETCH;
         end
         default: begin
            // Unused encodings recover to FETCH with every strobe low
            stateNext = FETCH;
         end
      endcase

      // Reset abandons any instruction in flight: present FETCH steering
      // with all strobes low so nothing is partially written.
      if (rst) begin
         iorD      = 1'b0;
         memWrite  = 1'b0;
         irWrite   = 1'b0;
         regDst    = 1'b0;
         memtoReg  = 1'b0;
         regWrite  = 1'b0;
         aluSrcA   = 1'b0;
         aluSrcB   = 2'd1;
         bZero     = 1'b0;
         aluOp     = ALUOP_ADD;
         pcSrc     = 2'd0;
         pcEn      = 1'b0;
         illegalOp = 1'b0;
      end
   end

   assign bus.IorD      = iorD;
   assign bus.MemWrite  = memWrite;
   assign bus.IRWrite   = irWrite;
   assign bus.RegDst    = regDst;
   assign bus.MemtoReg  = memtoReg;
   assign bus.RegWrite  = regWrite;
   assign bus.ALUSrcA   = aluSrcA;
   assign bus.ALUSrcB   = aluSrcB;
   assign bus.BZero     = bZero;
   assign bus.ALUOp     = aluOp;
   assign bus.PCSrc     = pcSrc;
   assign bus.PCEn      = pcEn;
   assign bus.IllegalOp = illegalOp;
   assign bus.State     = stateReg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Purpose:
//   Self-checking bench for multicycle_control_fsm. An instruction-level model
//   turns each directed instruction (opcode, funct, operand values) into the
//   list of cycles it must take and the control word of each cycle; a single
//   compare process checks the DUT against that list on every falling edge.
//   Reset behaviour is pinned with hand-written literal expectations.
//
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN (adds memory wait checks).
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   multicycle_control_fsm_if bus ();

   multicycle_control_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       iorD;
      logic       memWrite;
      logic       irWrite;
      logic       regDst;
      logic       memtoReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic       bZero;
      logic [2:0] aluOp;
      logic [1:0] pcSrc;
      logic       pcEn;
      logic       illegalOp;
   } cyc_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] funct;
      logic       rt;
      int         a;
      int         b;
   } vec_t;

   cyc_t  expQ[$];
   vec_t  vecs[$];
   string curName = "reset";
   int    total = 0;
   int    bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic cyc_t dutNow();
      cyc_t c;
      c.st        = bus.State;
      c.iorD      = bus.IorD;
      c.memWrite  = bus.MemWrite;
      c.irWrite   = bus.IRWrite;
      c.regDst    = bus.RegDst;
      c.memtoReg  = bus.MemtoReg;
      c.regWrite  = bus.RegWrite;
      c.aluSrcA   = bus.ALUSrcA;
      c.aluSrcB   = bus.ALUSrcB;
      c.bZero     = bus.BZero;
      c.aluOp     = bus.ALUOp;
      c.pcSrc     = bus.PCSrc;
      c.pcEn      = bus.PCEn;
      c.illegalOp = bus.IllegalOp;
      return c;
   endfunction

   function automatic cyc_t blank(input logic [3:0] st);
      cyc_t c;
      c    = '0;
      c.st = st;
      return c;
   endfunction

   // True for branches comparing rs against zero (blez/bgtz/bltz/bgez)
   function automatic bit singleOperand(input logic [5:0] op);
      return (op == 6'b000001) || (op == 6'b000110) || (op == 6'b000111);
   endfunction

   // Value the datapath ALU produces in the branch cycle
   function automatic int aluDiff(input vec_t v);
      return singleOperand(v.op) ? v.a : (v.a - v.b);
   endfunction

   // Instruction-level model: appends the expected cycles of one instruction
   function automatic void model(input vec_t v);
      cyc_t       c;
      int         cls;
      logic [2:0] immOp;
      bit         taken;
      // classes: 0 illegal, 1 R-type, 2 jr, 3 lw, 4 sw, 5 imm, 6 branch, 7 j
      cls   = 0;
      immOp = 3'd0;
      case (v.op)
         6'b000000: cls = (v.funct == 6'b001000) ? 2 : 1;
         6'b100011: cls = 3;
         6'b101011: cls = 4;
         6'b001000: begin cls = 5; immOp = 3'd0; end
         6'b001001: begin cls = 5; immOp = 3'd0; end
         6'b001100: begin cls = 5; immOp = 3'd3; end
         6'b001101: begin cls = 5; immOp = 3'd4; end
         6'b001110: begin cls = 5; immOp = 3'd5; end
         6'b001010: begin cls = 5; immOp = 3'd7; end
         6'b001011: begin cls = 5; immOp = 3'd7; end
         6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001: cls = 6;
         6'b000010: cls = 7;
         default:   cls = 0;
      endcase

      // Fetch: IR <= Mem[PC], PC <= PC + 4
      c = blank(4'd0); c.irWrite = 1'b1; c.aluSrcB = 2'd1; c.pcEn = 1'b1;
      expQ.push_back(c);
      // Decode: branch target precomputed
      c = blank(4'd1); c.aluSrcB = 2'd3;
      if (cls == 0) c.illegalOp = 1'b1;
      expQ.push_back(c);

      case (cls)
         1: begin
            c = blank(4'd6); c.aluSrcA = 1'b1; c.aluOp = 3'd2; expQ.push_back(c);
            c = blank(4'd7); c.regDst = 1'b1; c.regWrite = 1'b1; expQ.push_back(c);
         end
         2: begin
            c = blank(4'd12); c.pcSrc = 2'd3; c.pcEn = 1'b1; expQ.push_back(c);
         end
         3, 4: begin
            c = blank(4'd2); c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; expQ.push_back(c);
            if (cls == 3) begin
               c = blank(4'd3); c.iorD = 1'b1; expQ.push_back(c);
               c = blank(4'd4); c.memtoReg = 1'b1; c.regWrite = 1'b1; expQ.push_back(c);
            end else begin
               c = blank(4'd5); c.iorD = 1'b1; c.memWrite = 1'b1; expQ.push_back(c);
            end
         end
         5: begin
            c = blank(4'd9); c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.aluOp = immOp;
            expQ.push_back(c);
            c = blank(4'd10); c.regWrite = 1'b1; expQ.push_back(c);
         end
         6: begin
            // Branch decision straight from the MIPS semantics on rs/rt values
            case (v.op)
               6'b000100: taken = (v.a == v.b);
               6'b000101: taken = (v.a != v.b);
               6'b000110: taken = (v.a <= 0);
               6'b000111: taken = (v.a > 0);
               default:   taken = v.rt ? (v.a >= 0) : (v.a < 0);
            endcase
            c = blank(4'd8); c.aluSrcA = 1'b1; c.aluOp = 3'd1; c.pcSrc = 2'd1;
            c.bZero = singleOperand(v.op); c.pcEn = taken;
            expQ.push_back(c);
         end
         7: begin
            c = blank(4'd11); c.pcSrc = 2'd2; c.pcEn = 1'b1; expQ.push_back(c);
         end
         default: ;
      endcase
   endfunction

   // Single compare process: one expected cycle per falling edge
   always @(negedge clk) begin
      cyc_t e;
      cyc_t a;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         a = dutNow();
         check($sformatf("%s state", curName), 32'(a.st), 32'(e.st));
         check($sformatf("%s ctrl@st%0d", curName, e.st), 32'(a), 32'(e));
      end
   end

   // Must be called just after a rising edge with the DUT in FETCH
   task automatic runVec(input vec_t v);
      int r;
      int n0;
      int n;
      r         = aluDiff(v);
      curName   = v.name;
      bus.Op    = v.op;
      bus.Funct = v.funct;
      bus.RtLsb = v.rt;
      bus.Zero  = (r == 0);
      bus.Neg   = (r < 0);
      n0 = expQ.size();
      model(v);
      n = expQ.size() - n0;
      repeat (n) @(posedge clk);
      #1;
      $display("instr %-6s op=%b funct=%b rt=%0d a=%0d b=%0d cycles=%0d total=%0d bad=%0d",
               v.name, v.op, v.funct, v.rt, v.a, v.b, n, total, bad);
   endtask

   task automatic addVec(input string name, input logic [5:0] op, input logic [5:0] funct,
                         input logic rt, input int a, input int b);
      vec_t v;
      v.name = name; v.op = op; v.funct = funct; v.rt = rt; v.a = a; v.b = b;
      vecs.push_back(v);
   endtask

   initial begin
      cyc_t rstExp;
      vec_t v;

      addVec("add",    6'b000000, 6'b100000, 1'b0,  0,  0);
      addVec("sub",    6'b000000, 6'b100010, 1'b0,  0,  0);
      addVec("and",    6'b000000, 6'b100100, 1'b0,  0,  0);
      addVec("jr",     6'b000000, 6'b001000, 1'b0,  0,  0);
      addVec("lw",     6'b100011, 6'b000000, 1'b0,  0,  0);
      addVec("sw",     6'b101011, 6'b000000, 1'b0,  0,  0);
      addVec("addi",   6'b001000, 6'b000000, 1'b0,  0,  0);
      addVec("addiu",  6'b001001, 6'b000000, 1'b0,  0,  0);
      addVec("andi",   6'b001100, 6'b000000, 1'b0,  0,  0);
      addVec("ori",    6'b001101, 6'b000000, 1'b0,  0,  0);
      addVec("xori",   6'b001110, 6'b000000, 1'b0,  0,  0);
      addVec("slti",   6'b001010, 6'b000000, 1'b0,  0,  0);
      addVec("sltiu",  6'b001011, 6'b000000, 1'b0,  0,  0);
      addVec("beqT",   6'b000100, 6'b000000, 1'b0,  7,  7);
      addVec("beqN",   6'b000100, 6'b000000, 1'b0,  7,  3);
      addVec("bneT",   6'b000101, 6'b000000, 1'b0,  2,  9);
      addVec("bneN",   6'b000101, 6'b000000, 1'b0, -4, -4);
      addVec("blezT0", 6'b000110, 6'b000000, 1'b0,  0,  5);
      addVec("blezTn", 6'b000110, 6'b000000, 1'b0, -2,  5);
      addVec("blezN",  6'b000110, 6'b000000, 1'b0,  1,  5);
      addVec("bgtzT",  6'b000111, 6'b000000, 1'b0,  5, 99);
      addVec("bgtzN0", 6'b000111, 6'b000000, 1'b0,  0, 99);
      addVec("bgtzNn", 6'b000111, 6'b000000, 1'b0, -1,  0);
      addVec("bltzT",  6'b000001, 6'b000000, 1'b0, -3,  8);
      addVec("bltzN",  6'b000001, 6'b000000, 1'b0,  0,  8);
      addVec("bgezT",  6'b000001, 6'b000000, 1'b1,  0, -8);
      addVec("bgezTp", 6'b000001, 6'b000000, 1'b1,  6, 20);
      addVec("bgezN",  6'b000001, 6'b000000, 1'b1, -1,  0);
      addVec("j",      6'b000010, 6'b000000, 1'b0,  0,  0);
      addVec("ill3f",  6'b111111, 6'b000000, 1'b0,  0,  0);
      addVec("ill10",  6'b010000, 6'b000000, 1'b0,  0,  0);

      bus.Op    = 6'b111111;
      bus.Funct = 6'b000000;
      bus.RtLsb = 1'b0;
      bus.Zero  = 1'b0;
      bus.Neg   = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
      bus.MemReady = 1'b1;
`endif

      // Reset held 3 cycles: FETCH steering, all strobes low
      rstExp = blank(4'd0);
      rstExp.aluSrcB = 2'd1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset hold ctrl", 32'(dutNow()), 32'(rstExp));
      check("reset hold State", 32'(bus.State), 32'd0);

      // First cycle after release fetches
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("release PCEn", 32'(bus.PCEn), 32'd1);
      check("release IRWrite", 32'(bus.IRWrite), 32'd1);
      $display("reset released: State=%0d PCEn=%0d IRWrite=%0d", bus.State, bus.PCEn, bus.IRWrite);

      // Reset during a DECODE of an illegal opcode suppresses IllegalOp
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst in DECODE State", 32'(bus.State), 32'd1);
      check("rst in DECODE IllegalOp", 32'(bus.IllegalOp), 32'd0);
      check("rst in DECODE PCEn", 32'(bus.PCEn), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vecs[i]) begin
         v = vecs[i];
         runVec(v);
      end

      // Reset in MEMADR of a sw: instruction abandoned, no write issued
      curName   = "sw-rst";
      bus.Op    = 6'b101011;
      bus.Funct = 6'b000000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      rstExp.st = 4'd2;
      check("rst in MEMADR ctrl", 32'(dutNow()), 32'(rstExp));
      @(posedge clk); #1;
      @(negedge clk);
      check("rst abandon State", 32'(bus.State), 32'd0);
      check("rst abandon MemWrite", 32'(bus.MemWrite), 32'd0);
      $display("reset mid-sw: State=%0d MemWrite=%0d", bus.State, bus.MemWrite);
      @(posedge clk); #1;
      rst = 1'b0;
      runVec(vecs[4]);

`ifdef MULTICYCLE_MEM_WAIT_EN
      // FETCH stretched three cycles by MemReady=0
      curName      = "wait";
      bus.Op       = 6'b000010;
      bus.MemReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("wait fetch%0d State", k), 32'(bus.State), 32'd0);
         check($sformatf("wait fetch%0d PCEn", k), 32'(bus.PCEn), 32'd0);
         check($sformatf("wait fetch%0d IRWrite", k), 32'(bus.IRWrite), 32'd0);
      end
      #1;
      bus.MemReady = 1'b1;
      #1;
      check("wait ready PCEn", 32'(bus.PCEn), 32'd1);
      @(posedge clk); #1;
      check("wait ready next State", 32'(bus.State), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      $display("mem wait fetch: State=%0d", bus.State);

      // MEMWR held with MemWrite high until MemReady
      bus.Op = 6'b101011;
      repeat (3) @(posedge clk);
      #1;
      bus.MemReady = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("wait memwr%0d State", k), 32'(bus.State), 32'd5);
         check($sformatf("wait memwr%0d MemWrite", k), 32'(bus.MemWrite), 32'd1);
      end
      #1;
      bus.MemReady = 1'b1;
      @(posedge clk); #1;
      check("wait memwr exit State", 32'(bus.State), 32'd0);
      $display("mem wait write: State=%0d", bus.State);
`endif

      @(negedge clk);
      check("model queue drained", 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
